// File: rtl/mpuc_rot45.sv
// Time-multiplexed complex rotator by e^(-/+j*pi/4) with optional -j; one shared x181/256 multiplier.
// Latency 4 EI edges from sample accept to VO; EI=0 freezes all state, accepts one sample per 2 EI edges.
module mpuc_rot45 #(
  parameter int nb = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ei_i,
  input  logic                 ed_i,
  input  logic                 inv_i,
  input  logic                 mpyj_i,
  input  logic signed [nb-1:0] dr_i,
  input  logic signed [nb-1:0] di_i,
  output logic signed [nb:0]   dor_o,
  output logic signed [nb:0]   doi_o,
  output logic                 vo_o
);

  localparam int W  = nb + 1;
  localparam int PW = nb + 9;

  typedef enum logic {PH1 = 1'b0, PH2 = 1'b1} ph_e;

  ph_e                 ph_q, ph_d;
  logic                accept;
  logic                a_v_q, b_v_q, c_v_q, e_v_q, vo_q;
  logic signed [W-1:0] s_q, d_q, s_d, d_d;
  logic                inv_q, mpyj_q, mpyj_c_q;
  logic signed [W-1:0] rr_q, rr_c_q, ri_c_q;
  logic signed [W-1:0] e_dor_q, e_doi_q, e_dor_d, e_doi_d;
  logic signed [W-1:0] dor_q, doi_q;
  logic signed [W-1:0] mul_x, mul_f;
  logic signed [PW-1:0] xe, prod;

  always_comb begin
    ph_d   = ph_q;
    accept = 1'b0;
    if (ei_i) begin
      if (ph_q == PH1) begin
        if (ed_i) begin
          accept = 1'b1;
          ph_d   = PH2;
        end
      end else begin
        ph_d = PH1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ph_q <= PH1;
    else       ph_q <= ph_d;
  end

  assign s_d = {dr_i[nb-1], dr_i} + {di_i[nb-1], di_i};
  assign d_d = {dr_i[nb-1], dr_i} - {di_i[nb-1], di_i};

  // b_v_q marks the slot's second pipeline cycle: imaginary operand, otherwise real.
  always_comb begin
    mul_x = '0;
    if (b_v_q) mul_x = inv_q ? s_q : -d_q;
    else       mul_x = inv_q ? d_q : s_q;
  end

  assign xe    = {{8{mul_x[W-1]}}, mul_x};
  assign prod  = (xe <<< 7) + (xe <<< 5) + (xe <<< 4) + (xe <<< 2) + xe;
  assign mul_f = prod[PW-1:8];

  always_comb begin
    e_dor_d = rr_c_q;
    e_doi_d = ri_c_q;
    if (mpyj_c_q) begin
      e_dor_d = ri_c_q;
      e_doi_d = -rr_c_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ei_i) begin
      if (accept) begin
        s_q    <= s_d;
        d_q    <= d_d;
        inv_q  <= inv_i;
        mpyj_q <= mpyj_i;
      end
      if (a_v_q) rr_q <= mul_f;
      if (b_v_q) begin
        rr_c_q   <= rr_q;
        ri_c_q   <= mul_f;
        mpyj_c_q <= mpyj_q;
      end
      if (c_v_q) begin
        e_dor_q <= e_dor_d;
        e_doi_q <= e_doi_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_v_q <= 1'b0;
      b_v_q <= 1'b0;
      c_v_q <= 1'b0;
      e_v_q <= 1'b0;
      vo_q  <= 1'b0;
      dor_q <= '0;
      doi_q <= '0;
    end else if (ei_i) begin
      a_v_q <= accept;
      b_v_q <= a_v_q;
      c_v_q <= b_v_q;
      e_v_q <= c_v_q;
      vo_q  <= e_v_q;
      if (e_v_q) begin
        dor_q <= e_dor_q;
        doi_q <= e_doi_q;
      end
    end
  end

  assign dor_o = dor_q;
  assign doi_o = doi_q;
  assign vo_o  = vo_q;

endmodule

// File: tb/tb_mpuc_rot45.sv
// Scoreboard bench for mpuc_rot45: driver queues expected results, monitor checks them at VO.
module tb_mpuc_rot45;

  logic               clk = 1'b0;
  logic               rst, ei, ed, inv, mpyj, vo;
  logic        [11:0] dr, di;
  logic signed [12:0] dor, doi;

  always #5 clk = ~clk;

  mpuc_rot45 #(.nb(12)) dut (
    .clk_i(clk), .rst_i(rst), .ei_i(ei), .ed_i(ed), .inv_i(inv), .mpyj_i(mpyj),
    .dr_i(dr), .di_i(di), .dor_o(dor), .doi_o(doi), .vo_o(vo)
  );

  typedef struct {
    int r;
    int i;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ei_cnt = 0;
  bit   tb_ph  = 1'b0;

  function automatic int f181(input int x);
    int p;
    int qd;
    p  = 181 * x;
    qd = p / 256;
    if (p < 0 && (p % 256) != 0) qd = qd - 1;
    return qd;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // One clock: drive at negedge, update the protocol model, return after the posedge.
  task automatic cyc(input bit e, input bit d, input bit iv = 1'b0, input bit mj = 1'b0,
                     input int a = 0, input int b = 0, input bit r = 1'b0,
                     input bit hnd = 1'b0, input int hr = 0, input int hi = 0);
    int rr, ri;
    exp_t x;
    @(negedge clk);
    rst = r; ei = e; ed = d; inv = iv; mpyj = mj;
    dr = a[11:0]; di = b[11:0];
    if (r) begin
      q.delete();
      tb_ph = 1'b0;
    end else if (e) begin
      if (tb_ph) tb_ph = 1'b0;
      else if (d) begin
        tb_ph = 1'b1;
        if (hnd) begin
          x.r = hr; x.i = hi;
        end else begin
          rr = iv ? f181(a - b) : f181(a + b);
          ri = iv ? f181(a + b) : f181(b - a);
          x.r = mj ? ri : rr;
          x.i = mj ? -rr : ri;
        end
        x.due = ei_cnt + 5;
        q.push_back(x);
      end
    end
    @(posedge clk);
  endtask

  initial begin
    bit e_s;
    exp_t x;
    forever begin
      @(posedge clk);
      e_s = ei;
      #1;
      if (e_s) begin
        ei_cnt++;
        if (vo) begin
          if (q.size() == 0) begin
            check("unexpected_vo", 1, 0);
          end else begin
            x = q.pop_front();
            check("dor", int'(dor), x.r);
            check("doi", int'(doi), x.i);
            check("latency_edge", ei_cnt, x.due);
          end
        end
      end
    end
  end

  initial begin
    int a, b, n;
    rst = 1'b1; ei = 1'b0; ed = 1'b0; inv = 1'b0; mpyj = 1'b0; dr = '0; di = '0;
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    #1;
    check("reset_dor", int'(dor), 0);
    check("reset_doi", int'(doi), 0);
    check("reset_vo", int'(vo), 0);

    // Directed vectors with hand-computed results, some with stalls in flight.
    cyc(1, 1, 0, 0, 1000, 0, 0, 1, 707, -708);
    cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(1, 0);
    cyc(1, 1, 0, 0, 2047, 2047, 0, 1, 2894, 0);
    cyc(1, 0);
    cyc(1, 1, 0, 0, -2048, -2048, 0, 1, -2896, 0);
    cyc(1, 0);
    cyc(1, 1, 1, 0, 1000, 0, 0, 1, 707, 707);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 1, 1, 1000, 0, 0, 1, 707, -707);
    cyc(0, 0, 0, 0); cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 1, 1000, 0, 0, 1, -708, -707);
    cyc(1, 0);
    repeat (6) cyc(1, 0);

    // Consecutive ED: the second one is dropped; ED under EI=0 is ignored.
    cyc(1, 1, 0, 0, 1000, 0, 0, 1, 707, -708);
    cyc(1, 1, 1, 1, 555, 333);
    cyc(0, 1, 1, 1, 321, 123);
    repeat (6) cyc(1, 0);

    // Reset two EI edges after ED: in-flight sample dropped, outputs cleared.
    cyc(1, 1, 0, 0, 1000, 0);
    cyc(1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    #1;
    check("rst_mid_dor", int'(dor), 0);
    check("rst_mid_doi", int'(doi), 0);
    check("rst_mid_vo", int'(vo), 0);
    cyc(1, 1, 1, 0, 1000, 0, 0, 1, 707, 707);
    cyc(1, 0);
    repeat (6) cyc(1, 0);

    // Back-to-back random traffic with random stalls and mode changes mid-slot.
    for (int i = 0; i < 256; i++) begin
      a = int'($urandom_range(0, 4095)) - 2048;
      b = int'($urandom_range(0, 4095)) - 2048;
      if ($urandom_range(0, 3) == 0) cyc(0, 1'($urandom_range(0, 1)));
      cyc(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b);
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (n) cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, a);
    end
    repeat (10) cyc(1, 0);

    check("drained_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
